sram_access_fsm: RTL and testbench

Parametrised successor to the AVR-to-SRAM bus FSM, address shift register and address counter, merged into one block.
- Holds the SRAM address, loaded serially from the AVR (MSB first) or auto-incremented.
- Runs request/done handshaked read and write cycles with configurable wait states.
- Hands the SRAM address bus to the SNES side in SNES mode.
- Sits between the command decoder and the SRAM pins in the CPLD system.

---
 rtl/sram_access_fsm_if.sv | 13 +
 rtl/sram_access_fsm.sv | 106 ++++++++++
 tb/tb_sram_access_fsm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_fsm_if.sv
// sram_access_fsm_if: request/done handshake between the command decoder and the SRAM access FSM
interface sram_access_fsm_if #(
    parameter int DATA_W = 8
);
    logic              rd_req;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    modport master (output rd_req, wr_req, wr_data, input rd_data, busy, done);
    modport slave  (input rd_req, wr_req, wr_data, output rd_data, busy, done);
endinterface

// File: rtl/sram_access_fsm.sv
// sram_access_fsm: serial-loaded/auto-incrementing SRAM address plus wait-stated read/write cycle FSM
module sram_access_fsm #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 21,
    parameter int WAIT_STATES = 2,
    parameter int AUTO_INC    = 1
) (
    input  logic              avr_clk,
    input  logic              avr_reset_n,
    sram_access_fsm_if.slave  bus,
    input  logic              sreg_en_n,
    input  logic              addr_si,
    input  logic              cnt_inc,
    input  logic              snes_mode,
    input  logic [ADDR_W-1:0] snes_addr,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_din,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    logic [1:0]        state_q, state_d;
    logic              op_rd_q, op_rd_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] wr_buf_q, wr_buf_d;
    logic              snes_mode_r_q, snes_mode_r_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              data_oe_q, data_oe_d;
    logic              idle, accept, last;

    always_comb begin
        idle          = state_q == IDLE;
        accept        = idle && !snes_mode_r_q && sreg_en_n && !cnt_inc && (bus.rd_req || bus.wr_req);
        last          = state_q == ACCESS && cnt_q == 4'd0;
        state_d       = accept ? SETUP : state_q == SETUP ? ACCESS : last ? HOLD : state_q == HOLD ? IDLE : state_q;
        op_rd_d       = accept ? bus.rd_req : op_rd_q;
        wr_buf_d      = (accept && !bus.rd_req) ? bus.wr_data : wr_buf_q;
        cnt_d         = state_q == SETUP ? 4'(WAIT_STATES) : (state_q == ACCESS && !last) ? cnt_q - 4'd1 : cnt_q;
        // shift beats increment; the completed-access increment only happens leaving HOLD
        addr_d        = (idle && !sreg_en_n) ? {addr_q[ADDR_W-2:0], addr_si} :
                        ((idle && cnt_inc) || (state_q == HOLD && AUTO_INC != 0)) ? addr_q + ADDR_ONE : addr_q;
        rd_data_d     = (last && op_rd_q) ? sram_din : rd_data_q;
        snes_mode_r_d = idle ? snes_mode : snes_mode_r_q;
        ce_n_d        = state_d == IDLE;
        oe_n_d        = !(op_rd_d && (state_d == SETUP || state_d == ACCESS));
        we_n_d        = !(!op_rd_d && state_d == ACCESS);
        data_oe_d     = !op_rd_d && state_d != IDLE;
        busy_d        = state_d != IDLE;
        done_d        = state_d == HOLD;
    end

    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            state_q       <= IDLE;
            op_rd_q       <= 1'b0;
            cnt_q         <= 4'd0;
            addr_q        <= '0;
            rd_data_q     <= '0;
            wr_buf_q      <= '0;
            snes_mode_r_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            data_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_rd_q       <= op_rd_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            rd_data_q     <= rd_data_d;
            wr_buf_q      <= wr_buf_d;
            snes_mode_r_q <= snes_mode_r_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            data_oe_q     <= data_oe_d;
        end
    end

    assign sram_addr    = snes_mode_r_q ? snes_addr : addr_q;
    assign sram_dout    = wr_buf_q;
    assign sram_data_oe = data_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_sram_access_fsm.sv
// tb_sram_access_fsm: directed stimulus with a done-event scoreboard plus cycle-exact control checks
module tb_sram_access_fsm;
    logic        avr_clk = 1'b0;
    logic        avr_reset_n = 1'b0;
    logic        sreg_en_n = 1'b1, addr_si = 1'b0, cnt_inc = 1'b0, snes_mode = 1'b0;
    logic [20:0] snes_addr = '0;
    logic [20:0] sram_addr;
    logic [7:0]  sram_din = '0, sram_dout;
    logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
    int          n_cmp = 0, n_err = 0;

    typedef struct {
        logic        rd;
        logic [7:0]  data;
        logic [20:0] addr;
    } exp_t;
    exp_t sb[$];

    sram_access_fsm_if #(.DATA_W(8)) bus();

    sram_access_fsm #(.DATA_W(8), .ADDR_W(21), .WAIT_STATES(2), .AUTO_INC(1)) dut (
        .avr_clk(avr_clk), .avr_reset_n(avr_reset_n), .bus(bus),
        .sreg_en_n(sreg_en_n), .addr_si(addr_si), .cnt_inc(cnt_inc),
        .snes_mode(snes_mode), .snes_addr(snes_addr), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .sram_data_oe(sram_data_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 avr_clk = ~avr_clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge avr_clk);
        #2;
    endtask

    task automatic expect_done(logic rd, logic [7:0] d, logic [20:0] a);
        exp_t e;
        e.rd = rd; e.data = d; e.addr = a;
        sb.push_back(e);
    endtask

    task automatic shift_in(logic [20:0] v);
        for (int i = 20; i >= 0; i--) begin
            addr_si = v[i];
            sreg_en_n = 1'b0;
            tick();
        end
        sreg_en_n = 1'b1;
    endtask

    always @(negedge avr_clk) begin
        if (avr_reset_n && bus.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending access at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_addr", 32'(sram_addr), 32'(e.addr));
                if (e.rd) chk("rd_data", 32'(bus.rd_data), 32'(e.data));
                else begin
                    chk("wr_dout", 32'(sram_dout), 32'(e.data));
                    chk("wr_oe_at_done", 32'(sram_data_oe), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.wr_data = '0;
        tick(); tick();
        chk("rst_ce_n", 32'(sram_ce_n), 1);
        chk("rst_oe_n", 32'(sram_oe_n), 1);
        chk("rst_we_n", 32'(sram_we_n), 1);
        chk("rst_data_oe", 32'(sram_data_oe), 0);
        chk("rst_busy_done", {30'd0, bus.busy, bus.done}, 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        avr_reset_n = 1'b1;
        tick();

        shift_in(21'h04ccf);
        chk("load_addr", 32'(sram_addr), 32'h04ccf);
        chk("load_busy", 32'(bus.busy), 0);

        // read, WAIT_STATES=2
        sram_din = 8'haa; bus.rd_req = 1'b1;
        expect_done(1'b1, 8'haa, 21'h04ccf);
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.rd_req = 1'b0;
            chk($sformatf("rd_busy_c%0d", c), 32'(bus.busy), 32'(c <= 5));
            chk($sformatf("rd_oe_n_c%0d", c), 32'(sram_oe_n), 32'(!(c <= 4)));
            chk($sformatf("rd_ce_n_c%0d", c), 32'(sram_ce_n), 32'(c > 5));
            chk($sformatf("rd_done_c%0d", c), 32'(bus.done), 32'(c == 5));
        end
        chk("rd_addr_inc", 32'(sram_addr), 32'h04cd0);

        // write
        bus.wr_data = 8'hee; bus.wr_req = 1'b1;
        expect_done(1'b0, 8'hee, 21'h04cd0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.wr_req = 1'b0;
            chk($sformatf("wr_data_oe_c%0d", c), 32'(sram_data_oe), 32'(c <= 5));
            if (c <= 5) chk($sformatf("wr_dout_c%0d", c), 32'(sram_dout), 32'hee);
            chk($sformatf("wr_we_n_c%0d", c), 32'(sram_we_n), 32'(!(c >= 2 && c <= 4)));
            chk($sformatf("wr_oe_n_c%0d", c), 32'(sram_oe_n), 1);
            chk($sformatf("wr_done_c%0d", c), 32'(bus.done), 32'(c == 5));
        end
        chk("wr_addr_inc", 32'(sram_addr), 32'h04cd1);

        // read and write together: only the read happens
        sram_din = 8'h3c; bus.wr_data = 8'h55; bus.rd_req = 1'b1; bus.wr_req = 1'b1;
        expect_done(1'b1, 8'h3c, 21'h04cd1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.rd_req = 1'b0; bus.wr_req = 1'b0;
            chk($sformatf("both_we_n_c%0d", c), 32'(sram_we_n), 1);
            chk($sformatf("both_data_oe_c%0d", c), 32'(sram_data_oe), 0);
        end
        chk("both_wbuf_kept", 32'(sram_dout), 32'hee);
        chk("both_addr_inc", 32'(sram_addr), 32'h04cd2);

        // counter wrap
        shift_in(21'h1fffff);
        chk("ones_loaded", 32'(sram_addr), 32'h1fffff);
        cnt_inc = 1'b1;
        tick();
        cnt_inc = 1'b0;
        chk("cnt_wrap", 32'(sram_addr), 0);

        // cnt_inc while busy is ignored
        sram_din = 8'h77; bus.rd_req = 1'b1;
        expect_done(1'b1, 8'h77, 21'h0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.rd_req = 1'b0;
            cnt_inc = (c <= 4);
        end
        chk("cnt_busy_ignored", 32'(sram_addr), 1);

        // shift and cnt_inc together: shift only, and the request is blocked
        sreg_en_n = 1'b0; addr_si = 1'b1; cnt_inc = 1'b1; bus.rd_req = 1'b1;
        tick();
        sreg_en_n = 1'b1; cnt_inc = 1'b0; bus.rd_req = 1'b0;
        chk("shift_over_inc", 32'(sram_addr), 3);
        chk("shift_blocks_req", 32'(bus.busy), 0);
        tick();
        chk("shift_blocks_req2", 32'(bus.busy), 0);

        // SNES mode owns the bus and masks requests
        snes_mode = 1'b1; snes_addr = 21'h123456;
        tick();
        chk("snes_addr", 32'(sram_addr), 32'h123456);
        bus.rd_req = 1'b1;
        tick(); tick();
        chk("snes_rd_ignored", 32'(bus.busy), 0);
        chk("snes_ce_n", 32'(sram_ce_n), 1);
        bus.rd_req = 1'b0; snes_mode = 1'b0;
        tick();
        chk("snes_release", 32'(sram_addr), 3);

        // SNES mode asserted mid-read: read finishes first
        sram_din = 8'h99; bus.rd_req = 1'b1;
        expect_done(1'b1, 8'h99, 21'h3);
        for (int c = 1; c <= 7; c++) begin
            tick();
            bus.rd_req = 1'b0;
            if (c == 2) snes_mode = 1'b1;
            if (c <= 5) chk($sformatf("snes_mid_addr_c%0d", c), 32'(sram_addr), 3);
        end
        chk("snes_after_idle", 32'(sram_addr), 32'h123456);
        snes_mode = 1'b0;
        tick();
        chk("snes_back", 32'(sram_addr), 4);

        // reset in ACCESS aborts with no done
        sram_din = 8'h11; bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick(); tick();
        avr_reset_n = 1'b0;
        #1;
        chk("abort_ce_n", 32'(sram_ce_n), 1);
        chk("abort_oe_n", 32'(sram_oe_n), 1);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_addr", 32'(sram_addr), 0);
        chk("abort_rd_data", 32'(bus.rd_data), 0);
        tick();
        avr_reset_n = 1'b1;
        for (int c = 0; c < 6; c++) tick();

        sram_din = 8'h5a; bus.rd_req = 1'b1;
        expect_done(1'b1, 8'h5a, 21'h0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            bus.rd_req = 1'b0;
        end
        chk("post_reset_addr", 32'(sram_addr), 1);
        chk("post_reset_rd", 32'(bus.rd_data), 32'h5a);

        tick(); tick();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
